// File: rtl/game_ctrl.sv
// Game-level play sequencer: lives, enemy count, death freeze, respawn, invulnerability, game over / win.
// Optional GAME_CTRL_BLINK_EN: bm_visible blinks every 8 frames while invulnerable.
module game_ctrl #(
  parameter int unsigned LIVES         = 3,
  parameter int unsigned NUM_ENEMIES   = 6,
  parameter int unsigned DEATH_FRAMES  = 60,
  parameter int unsigned INVULN_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       move_req,
  input  logic       hit,
  input  logic       enemy_killed,
  output logic [2:0] state,
  output logic [2:0] lives,
  output logic [3:0] enemies_left,
  output logic       freeze,
  output logic       enemy_start,
  output logic       respawn,
  output logic       invuln,
  output logic       bm_visible,
  output logic       game_over,
  output logic       game_won
);

  localparam int unsigned LW = 3;
  localparam int unsigned EW = 4;
  localparam int unsigned CW = 8;

  localparam logic [LW-1:0] LIVES_INIT   = LW'(LIVES);
  localparam logic [EW-1:0] ENEMIES_INIT = EW'(NUM_ENEMIES);
  localparam logic [CW-1:0] DEATH_LOAD   = CW'(DEATH_FRAMES);
  localparam logic [CW-1:0] INVULN_LOAD  = CW'(INVULN_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAY    = 3'd1,
    S_DYING   = 3'd2,
    S_RESPAWN = 3'd3,
    S_INVULN  = 3'd4,
    S_OVER    = 3'd5,
    S_WIN     = 3'd6
  } state_t;

  state_t        st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lives_d;
  logic [EW-1:0] en_d;
  logic          vis_d;
  logic          kill_dec;
  logic          last_kill;
`ifdef GAME_CTRL_BLINK_EN
  logic [2:0]    blk_q, blk_d;
`endif

  assign state = st_q;

  // Next-state, counters and score bookkeeping.
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    lives_d  = lives;
    en_d     = enemies_left;
    vis_d    = 1'b1;
`ifdef GAME_CTRL_BLINK_EN
    blk_d    = blk_q;
`endif
    kill_dec  = enemy_killed && (enemies_left != '0) &&
                (st_q != S_IDLE) && (st_q != S_OVER) && (st_q != S_WIN);
    last_kill = enemy_killed && (enemies_left == EW'(1));
    if (kill_dec) en_d = enemies_left - EW'(1);

    case (st_q)
      S_IDLE: begin
        lives_d = LIVES_INIT;
        en_d    = ENEMIES_INIT;
        if (move_req) st_d = S_PLAY;
      end
      S_PLAY: begin
        if (hit) begin
          st_d  = S_DYING;
          cnt_d = DEATH_LOAD;
          if (lives != '0) lives_d = lives - LW'(1);
        end else if (last_kill) begin
          st_d = S_WIN;
        end
      end
      S_DYING: begin
        // A kill landing alongside the fatal hit still wins once the freeze ends.
        if (cnt_q == '0) begin
          if (en_d == '0)       st_d = S_WIN;
          else if (lives == '0) st_d = S_OVER;
          else                  st_d = S_RESPAWN;
        end else if (frame_tick) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESPAWN: begin
        st_d  = S_INVULN;
        cnt_d = INVULN_LOAD;
`ifdef GAME_CTRL_BLINK_EN
        blk_d = '0;
`endif
      end
      S_INVULN: begin
        if (last_kill) begin
          st_d = S_WIN;
        end else if (cnt_q == '0) begin
          st_d = S_PLAY;
        end else begin
          if (frame_tick) cnt_d = cnt_q - CW'(1);
`ifdef GAME_CTRL_BLINK_EN
          vis_d = bm_visible;
          if (frame_tick) begin
            blk_d = blk_q + 3'd1;
            if (blk_q == 3'd7) vis_d = ~bm_visible;
          end
`endif
        end
      end
      S_OVER, S_WIN: begin
        if (start) begin
          st_d    = S_IDLE;
          lives_d = LIVES_INIT;
          en_d    = ENEMIES_INIT;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  // State, counters and outputs decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q         <= S_IDLE;
      cnt_q        <= '0;
      lives        <= LIVES_INIT;
      enemies_left <= ENEMIES_INIT;
      freeze       <= 1'b0;
      enemy_start  <= 1'b0;
      respawn      <= 1'b0;
      invuln       <= 1'b0;
      bm_visible   <= 1'b1;
      game_over    <= 1'b0;
      game_won     <= 1'b0;
`ifdef GAME_CTRL_BLINK_EN
      blk_q        <= '0;
`endif
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      lives        <= lives_d;
      enemies_left <= en_d;
      freeze       <= (st_d == S_DYING) || (st_d == S_RESPAWN) ||
                      (st_d == S_OVER)  || (st_d == S_WIN);
      enemy_start  <= (st_d == S_PLAY) || (st_d == S_INVULN);
      respawn      <= (st_d == S_RESPAWN);
      invuln       <= (st_d == S_INVULN);
      bm_visible   <= vis_d;
      game_over    <= (st_d == S_OVER);
      game_won     <= (st_d == S_WIN);
`ifdef GAME_CTRL_BLINK_EN
      blk_q        <= blk_d;
`endif
    end
  end

endmodule
